mult32_seq_signed: RTL and testbench

- Sequential signed multiplier: 32-bit two's-complement A times 32-bit two's-complement B gives a 64-bit product, split into HI (bits 63:32) and LO (bits 31:0).
- Serves as the integer-multiply unit of the datapath's execute stage.
- Uses radix-2 Booth recoding, one Booth step per clock, with a START/DONE handshake.
- Result registers hold the last product until the next operation completes.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult32_booth_step.sv | 44 ++++
 rtl/mult32_seq_signed.sv | 113 +++++++++++
 tb/tb_mult32_seq_signed.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mult_pkg
// Description : Shared types and constants for the sequential signed
//               Booth multiplier (operand width, FSM state encoding,
//               step-counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Default operand width; HI and LO are each this wide.
  localparam int MULT_WIDTH = 32;

  // Step counter counts MULT_WIDTH-1 down to 0.
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

  // Controller states. Prefixed so they never collide with the DONE port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult32_booth_step.sv
`default_nettype none
// ============================================================================
// Module      : mult32_booth_step
// Description : One radix-2 Booth iteration. Inspects the two LSBs of the
//               (2*WIDTH+1)-bit accumulator, adds/subtracts the multiplicand
//               into the upper WIDTH bits, then arithmetic-shifts right by 1.
// Revision    : 1.0 - initial release
// ============================================================================
module mult32_booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [2*WIDTH:0] acc_o
);

  // Upper partial-product field of the accumulator.
  logic [WIDTH-1:0] w_upper;
  // Sign-extended copies so the add/subtract cannot lose its sign: e.g.
  // 0 - (-2^(WIDTH-1)) needs WIDTH+1 bits to stay positive.
  logic [WIDTH:0]   w_upper_x;
  logic [WIDTH:0]   w_mcand_x;
  logic [WIDTH:0]   w_sum;

  assign w_upper   = acc_i[2*WIDTH:WIDTH+1];
  assign w_upper_x = {w_upper[WIDTH-1], w_upper};
  assign w_mcand_x = {mcand_i[WIDTH-1], mcand_i};

  // Booth recoding of the current multiplier bit pair {b(i), b(i-1)}.
  always_comb begin
    w_sum = w_upper_x;
    case (acc_i[1:0])
      2'b01:   w_sum = w_upper_x + w_mcand_x;
      2'b10:   w_sum = w_upper_x - w_mcand_x;
      default: w_sum = w_upper_x;
    endcase
  end

  // Arithmetic shift right: the true sign of the widened sum becomes the new
  // MSB, and the multiplier bit just consumed drops out at the bottom.
  assign acc_o = {w_sum[WIDTH], w_sum, acc_i[WIDTH:1]};

endmodule : mult32_booth_step
`default_nettype wire

// File: rtl/mult32_seq_signed.sv
`default_nettype none
// ============================================================================
// Module      : mult32_seq_signed
// Description : Sequential WIDTH x WIDTH signed multiplier for the execute
//               stage. One Booth step per clock, START/DONE handshake,
//               registered HI/LO that hold until the next completion.
// Revision    : 1.0 - initial release
// ============================================================================
module mult32_seq_signed
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = (WIDTH == MULT_WIDTH) ? MULT_CNT_W : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t         state_q, state_d;
  logic [2*WIDTH:0]    acc_q,   acc_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0]    hi_q,    hi_d;
  logic [WIDTH-1:0]    lo_q,    lo_d;

  // Accumulator value after the Booth step for the current cycle.
  logic [2*WIDTH:0]    step_acc;

  mult32_booth_step #(
    .WIDTH (WIDTH)
  ) u_booth_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic: capture in IDLE, step in RUN, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          mcand_d = A;
          // Multiplier in the low half with a zero "b(-1)" guard bit.
          acc_d   = {{WIDTH{1'b0}}, B, 1'b0};
          cnt_d   = CNT_LAST;
        end
      end

      ST_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          // Last step: publish the product straight from the step output so
          // the result and DONE appear on the same edge.
          state_d = ST_DONE;
          hi_d    = step_acc[2*WIDTH:WIDTH+1];
          lo_d    = step_acc[WIDTH:1];
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign BUSY = (state_q != ST_IDLE);
  assign DONE = (state_q == ST_DONE);

endmodule : mult32_seq_signed
`default_nettype wire

// File: tb/tb_mult32_seq_signed.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult32_seq_signed
// Description : Self-checking bench for mult32_seq_signed: directed product
//               table, handshake/back-to-back/reset sequences, random pairs
//               against a 64-bit signed reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult32_seq_signed;

  localparam int W       = 32;
  localparam int LAT     = 32;
  localparam int TIMEOUT = 100;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         BUSY;
  logic         DONE;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[15];

  mult32_seq_signed #(
    .WIDTH (W)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .HI    (HI),
    .LO    (LO),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one operation, measure DONE latency and pulse width, return result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag,
                        input bit check_timing, output logic [63:0] res);
    int n;
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(posedge CLK);             // accepting edge k
    #1 START = 1'b0;
    n = 0;
    while (n < TIMEOUT) begin
      @(posedge CLK);
      #1 n++;
      if (DONE) break;
    end
    if (n >= TIMEOUT) begin
      chk({tag, "_timeout"}, 64'(n), 64'(LAT));
      res = '0;
    end else begin
      res = {HI, LO};
      if (check_timing) begin
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        @(posedge CLK);
        #1 chk({tag, "_done_fall"}, 64'({DONE, BUSY}), 64'(0));
      end else begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  logic [63:0]        res;
  logic signed [63:0] sa, sb, ref_p;
  int                 done_cnt;
  int                 first_done;
  int                 second_done;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    START  = 1'b0;
    A      = '0;
    B      = '0;
    RST_N  = 1'b1;

    vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
    vecs[4]  = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'h0000_0003};
    vecs[5]  = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
    vecs[6]  = '{32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 32'h0000_0009};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[9]  = '{32'h7FFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[11] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000};
    vecs[12] = '{32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[13] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[14] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

    // Reset state
    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk("reset_state", {HI, LO}, 64'h0);
    chk("reset_flags", 64'({BUSY, DONE}), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed product table
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), 1'b1, res);
      chk($sformatf("vec%0d_prod", i), res, {vecs[i].hi, vecs[i].lo});
    end

    // START pulses and operand changes while busy are ignored
    @(negedge CLK);
    A = 32'd5; B = 32'd7; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    A = 32'd100; B = 32'd100;
    done_cnt   = 0;
    first_done = 0;
    for (int n = 1; n <= LAT + 8; n++) begin
      @(negedge CLK);
      START = (n == 5 || n == 20 || n == LAT);
      @(posedge CLK);
      #1;
      if (DONE) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = n;
          res = {HI, LO};
        end
      end
    end
    START = 1'b0;
    chk("busy_ignore_done_cnt", 64'(done_cnt), 64'(1));
    chk("busy_ignore_latency", 64'(first_done), 64'(LAT));
    chk("busy_ignore_prod", res, 64'd35);
    chk("busy_ignore_idle", 64'(BUSY), 64'(0));

    // Back-to-back: START held high, second op accepted at k+34
    @(negedge CLK);
    A = 32'd3; B = 32'd3; START = 1'b1;
    @(posedge CLK);             // edge k
    #1 A = 32'd2; B = 32'd2;
    first_done  = 0;
    second_done = 0;
    for (int n = 1; n <= 2 * LAT + 6; n++) begin
      @(posedge CLK);
      #1;
      if (n == LAT + 2) START = 1'b0;
      if (DONE) begin
        if (first_done == 0) begin
          first_done = n;
          chk("b2b_first_prod", {HI, LO}, 64'd9);
        end else if (second_done == 0) begin
          second_done = n;
          chk("b2b_second_prod", {HI, LO}, 64'd4);
        end
      end
    end
    chk("b2b_first_edge", 64'(first_done), 64'(LAT));
    chk("b2b_second_edge", 64'(second_done), 64'(LAT + 2 + LAT));

    // Asynchronous reset in the middle of a run
    @(negedge CLK);
    A = 32'h1234_5678; B = 32'h0000_0009; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk("midreset_prod", {HI, LO}, 64'h0);
    chk("midreset_flags", 64'({BUSY, DONE}), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    run_op(32'd3, 32'd3, "post_reset", 1'b1, res);
    chk("post_reset_prod", res, 64'd9);

    // Random signed pairs against a 64-bit signed reference
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = {ra[31], 31'h0};
      sa    = $signed(ra);
      sb    = $signed(rb);
      ref_p = sa * sb;
      run_op(ra, rb, "rand", 1'b0, res);
      if (res !== ref_p)
        $display("FAIL rand%0d: A=%h B=%h got %h expected %h", i, ra, rb, res, ref_p);
      n_chk++;
      if (res !== ref_p) n_fail++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mult32_seq_signed
`default_nettype wire
